// File: rtl/imem_pkg.sv
// Shared constants and loader state type for the instruction memory.
// Imported by the loader and by the fetch-side memory.
package imem_pkg;
  localparam int MEM_BYTES = 64;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    WORD,
    WRITE,
    DONE,
    ERROR
  } loader_state_t;
endpackage

// File: rtl/imem_loader_word_serializer.sv
// Turns one latched 32-bit word into four big-endian byte writes.
// The MSB goes to the base address; last flags the final byte.
module word_serializer #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [31:0]       word,
  input  logic [ADDR_W-1:0] base,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              last
);
  logic [1:0]  b;
  logic [23:0] rest;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rest    <= '0;
      b       <= '0;
    end else if (load) begin
      wr_en   <= 1'b1;
      wr_addr <= base;
      wr_data <= word[31:24];
      rest    <= word[23:0];
      b       <= '0;
    end else if (wr_en) begin
      if (b == 2'd3) begin
        wr_en <= 1'b0;
      end else begin
        b       <= b + 2'd1;
        wr_addr <= wr_addr + ADDR_W'(1);
        wr_data <= rest[23:16];
        rest    <= {rest[15:0], 8'h00};
      end
    end
  end

  assign last = wr_en & (b == 2'd3);
endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed word stream into byte-wide instruction memory
// and holds the CPU off until a complete program is present.
module imem_loader #(
  parameter int MEM_BYTES = imem_pkg::MEM_BYTES,
  parameter int ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);
  import imem_pkg::*;

  localparam int WORDS = MEM_BYTES / BYTES_PER_WORD;
  localparam int KW    = $clog2(WORDS + 1);

  loader_state_t state, nxt;
  logic [KW-1:0] k, n;
  logic          hs, idle_like, last, load;
  logic [ADDR_W-1:0] base;

  assign idle_like = (state == IDLE) | (state == DONE) | (state == ERROR);
  assign in_ready  = (state == HEADER) | (state == WORD);
  assign hs        = in_valid & in_ready;
  assign load      = (state == WORD) & hs;
  assign base      = {k[ADDR_W-3:0], 2'b00};

  assign busy     = (state == HEADER) | (state == WORD) | (state == WRITE);
  assign done     = (state == DONE);
  assign error    = (state == ERROR);
  assign cpu_hold = (state != DONE);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE, ERROR: if (start) nxt = HEADER;
      HEADER: begin
        if (hs) begin
          if (in_data == 32'd0)            nxt = DONE;
          else if (in_data > 32'(WORDS))   nxt = ERROR;
          else                             nxt = WORD;
        end
      end
      WORD:  if (hs) nxt = WRITE;
      WRITE: if (last) nxt = ((k + KW'(1)) < n) ? WORD : DONE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      k     <= '0;
      n     <= '0;
    end else begin
      state <= nxt;
      if (idle_like && start)       k <= '0;
      if (state == HEADER && hs)    n <= in_data[KW-1:0];
      if (state == WRITE && last)   k <= k + KW'(1);
    end
  end

  word_serializer #(.ADDR_W(ADDR_W)) u_ser (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .word    (in_data),
    .base    (base),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .last    (last)
  );
endmodule

// File: doc/imem_loader.md
# imem_loader

Writer side of the byte-addressed, big-endian instruction memory. Accepts a word stream over a valid/ready handshake: first a length header, then instruction words. Serialises each word into four byte writes at consecutive addresses, most-significant byte at the lowest address. Holds the CPU off (`cpu_hold`) until a complete program has been written, so the fetch path then reads `memory[pc]..memory[pc+3]` as bits 31:24..7:0.

## Interface
Parameters:
- `MEM_BYTES`, 64: instruction memory capacity in bytes; must be a multiple of 4.
- `ADDR_W`, 6: byte address width, equal to log2(MEM_BYTES).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a load.
- `in_valid`  in  1  source has a word on `in_data`.
- `in_ready`  out  1  loader accepts a word this cycle. Transfer occurs when `in_valid & in_ready` at a rising edge.
- `in_data`  in  32  header word or instruction word.
- `wr_en`  out  1  byte write strobe to instruction memory.
- `wr_addr`  out  ADDR_W  byte address.
- `wr_data`  out  8  byte to write.
- `busy`  out  1  load in progress (HEADER or WORD/WRITE states).
- `done`  out  1  last load completed successfully; sticky.
- `error`  out  1  last header was rejected; sticky.
- `cpu_hold`  out  1  CPU must not fetch while high.

## Operation
- States: IDLE, HEADER, WORD, WRITE, DONE, ERROR.
- Reset values: state IDLE, `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `error`=0, `cpu_hold`=1.
- **IDLE, DONE, ERROR:**
  - `start` moves to HEADER.
  - On that move, clear `done` and `error`, set `cpu_hold`=1, and reset the word index k to 0.
- **HEADER:**
  - `in_ready`=1.
  - On transfer, N = `in_data` (unsigned, full 32 bits).
  - N=0 goes to DONE.
  - N>MEM_BYTES/4 goes to ERROR.
  - Otherwise, latch N and go to WORD.
- **WORD:**
  - `in_ready`=1.
  - On transfer, latch the word, set byte index b=0, and go to WRITE.
- **WRITE:**
  - Each cycle, `wr_en`=1, `wr_addr`=4k+b, `wr_data`=word[31-8b -: 8].
  - After b=3, increment k.
  - Go to WORD if k<N, else DONE.
- **DONE:** `done`=1, `busy`=0, `cpu_hold`=0.
- **ERROR:** `error`=1, `busy`=0, `cpu_hold`=1. No writes occur.
- `start` while `busy` is ignored.
- `in_valid` outside HEADER/WORD is ignored: `in_ready`=0 and nothing is consumed.
- Address arithmetic is ADDR_W bits wide. With N≤MEM_BYTES/4, 4k+b never wraps.
- Reset mid-load returns to the reset values immediately. Bytes already written stay in memory, and `cpu_hold` stays 1.
- `in_ready` is decoded from state. All write-side outputs are registered.

## Timing
- `start` sampled at edge t: HEADER state and `in_ready`=1 in the cycle after t.
- Header transfer at edge h:
  - N valid: WORD in the cycle after h.
  - N=0: `done`=1 and `cpu_hold`=0 in the cycle after h.
  - N too large: `error`=1 in the cycle after h.
- Word transfer at edge w:
  - `wr_en`=1 in each of the four cycles after w, bytes 0..3 in order.
  - `in_ready`=0 during those four cycles.
  - The next state (WORD or DONE) takes effect four cycles after the last write cycle begins' predecessor, i.e. at the fifth cycle after w.
- Peak throughput: one word per 5 cycles.
- `in_valid` may be held high continuously; each word is taken exactly once.
- Full load of N words from the header transfer takes 5N cycles to DONE.

## Structure
- Shared package `imem_pkg` holds:
  - `MEM_BYTES`;
  - `BYTES_PER_WORD`=4;
  - the loader state enum `loader_state_t`.
- The fetch-side memory imports the same `MEM_BYTES`.
- One sub-module is natural: `word_serializer`. It takes a latched 32-bit word plus base address and emits four big-endian byte writes with a `last` flag. The FSM, counters and handshake stay in `imem_loader`.

## Test plan
- **Reset:** assert `reset` mid-WRITE. Next cycle: all outputs at reset values, `cpu_hold`=1, no further `wr_en`.
- **Single word:** `start`, header 1, word 0x8B020020.
  - Writes, on consecutive cycles: addr0=0x8B, addr1=0x02, addr2=0x00, addr3=0x20.
  - Then `done`=1, `cpu_hold`=0.
  - A fetch-side model reading pc=0 returns 0x8B020020.
- **Full memory:** header 16, words 0x00000000..0x0000000F with `in_valid` held high.
  - 64 writes total; last write is addr 63, data 0x0F.
  - `done` asserts 80 cycles after the header transfer.
- **Bad header:** header 17 gives `error`=1, zero writes, `cpu_hold`=1. A subsequent `start` clears `error` and returns to HEADER.
- **Empty load:** header 0 gives `done`=1 the next cycle with no writes.
- **Backpressure and ignored start:**
  - `in_valid` toggled randomly during a 3-word load: exactly 12 writes, in order.
  - `start` pulsed mid-load: no effect.
